// File: rtl/uart_retrans_pkg.sv
// uart_retrans_pkg: state encoding and default parameters shared by the
// UART retransmit controller and its timeout timer.
package uart_retrans_pkg;
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_RESEND,
        ST_RELEASE,
        ST_ERROR
    } state_t;

    localparam int DEF_DATA_W      = 8;
    localparam int DEF_MAX_RETRY   = 2;
    localparam int DEF_TIMEOUT_CYC = 64;
endpackage

// File: rtl/uart_retrans_timer.sv
// uart_retrans_timer: saturating resend-wait counter; o_expired is high while
// the count sits at TIMEOUT_CYC-1.
module uart_retrans_timer
    import uart_retrans_pkg::*;
#(
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

    logic [TW-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_enable && r_cnt != LAST)
            r_cnt <= r_cnt + TW'(1);
    end

    assign o_expired = r_cnt == LAST;
endmodule

// File: rtl/uart_retrans_ctrl.sv
// uart_retrans_ctrl: holds good UART frames for a downstream consumer and asks
// the transmitter to resend bad or missing frames, up to MAX_RETRY times.
module uart_retrans_ctrl
    import uart_retrans_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MAX_RETRY   = DEF_MAX_RETRY,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_rx_valid,
    input  logic [DATA_W-1:0] i_rx_data,
    input  logic              i_parity_err,
    input  logic              i_ack,
    input  logic              i_err_clr,
    output logic [DATA_W-1:0] o_data_out,
    output logic              o_valid,
    output logic              o_request_resend,
    output logic              o_error,
    output logic              o_overrun,
    output logic [3:0]        o_retry_cnt
);
    localparam logic [3:0] MAX_R = 4'(MAX_RETRY);

    state_t            r_state, w_state_nx;
    logic [DATA_W-1:0] r_data, w_data_nx;
    logic [3:0]        r_retry, w_retry_nx;
    logic              r_req, w_req_nx;
    logic              r_ovr, w_ovr_nx;
    logic              w_good, w_bad, w_fail, w_expired, w_tclr;

    assign w_good = i_rx_valid & ~i_parity_err;
    assign w_bad  = i_rx_valid & i_parity_err;
    assign w_tclr = (r_state != ST_WAIT_RESEND) | w_fail;

    uart_retrans_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (w_tclr),
        .i_enable (r_state == ST_WAIT_RESEND),
        .o_expired(w_expired)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_data  <= '0;
            r_retry <= '0;
            r_req   <= 1'b0;
            r_ovr   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_data  <= w_data_nx;
            r_retry <= w_retry_nx;
            r_req   <= w_req_nx;
            r_ovr   <= w_ovr_nx;
        end
    end

    // A bad frame in the cycle right after a resend request cannot be the
    // resent frame, so it is ignored; this also keeps pulses non-adjacent.
    always_comb begin
        w_state_nx = r_state;
        w_data_nx  = r_data;
        w_retry_nx = r_retry;
        w_req_nx   = 1'b0;
        w_ovr_nx   = 1'b0;
        w_fail     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_fail = w_bad;
                if (w_good) begin
                    w_state_nx = ST_RELEASE;
                    w_data_nx  = i_rx_data;
                    w_retry_nx = '0;
                end
            end
            ST_WAIT_RESEND: begin
                if (w_good) begin
                    w_state_nx = ST_RELEASE;
                    w_data_nx  = i_rx_data;
                end else
                    w_fail = (w_bad & ~r_req) | (~i_rx_valid & w_expired);
            end
            ST_RELEASE: begin
                w_ovr_nx = i_rx_valid & ~r_ovr;
                if (i_ack) begin
                    w_state_nx = ST_IDLE;
                    w_retry_nx = '0;
                end
            end
            default: begin
                if (i_err_clr) begin
                    w_state_nx = ST_IDLE;
                    w_retry_nx = '0;
                end
            end
        endcase
        if (w_fail) begin
            if (r_retry < MAX_R) begin
                w_req_nx   = 1'b1;
                w_retry_nx = r_retry + 4'd1;
                w_state_nx = ST_WAIT_RESEND;
            end else
                w_state_nx = ST_ERROR;
        end
    end

    assign o_data_out       = r_data;
    assign o_valid          = r_state == ST_RELEASE;
    assign o_error          = r_state == ST_ERROR;
    assign o_request_resend = r_req;
    assign o_overrun        = r_ovr;
    assign o_retry_cnt      = r_retry;
endmodule

// File: tb/tb_uart_retrans_ctrl.sv
// tb_uart_retrans_ctrl: directed stimulus against a cycle-level behavioural
// model of the retransmit rules, plus hand-computed literal checks.
module tb_uart_retrans_ctrl;
    localparam int TO   = 16;
    localparam int MAXR = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx_valid = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       parity_err = 1'b0;
    logic       ack = 1'b0;
    logic       err_clr = 1'b0;
    logic [7:0] data_out;
    logic       valid, request_resend, error, overrun;
    logic [3:0] retry_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    uart_retrans_ctrl #(.DATA_W(8), .MAX_RETRY(MAXR), .TIMEOUT_CYC(TO)) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_rx_valid      (rx_valid),
        .i_rx_data       (rx_data),
        .i_parity_err    (parity_err),
        .i_ack           (ack),
        .i_err_clr       (err_clr),
        .o_data_out      (data_out),
        .o_valid         (valid),
        .o_request_resend(request_resend),
        .o_error         (error),
        .o_overrun       (overrun),
        .o_retry_cnt     (retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Model: holding a frame, faulted, waiting for a resend (with its age in
    // cycles), number of resends asked for, and the two pulses.
    bit         m_hold, m_fault, m_wait, m_req, m_ovr, m_fail, m_preq, m_povr;
    int         m_age, m_tries;
    logic [7:0] m_data;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_hold = 0; m_fault = 0; m_wait = 0; m_req = 0; m_ovr = 0;
            m_age = 0; m_tries = 0; m_data = 8'h00;
        end else begin
            m_preq = m_req;
            m_povr = m_ovr;
            m_req  = 0;
            m_ovr  = 0;
            m_fail = 0;
            if (m_fault) begin
                if (err_clr) begin
                    m_fault = 0;
                    m_tries = 0;
                end
            end else if (m_hold) begin
                m_ovr = rx_valid && !m_povr;
                if (ack) begin
                    m_hold  = 0;
                    m_tries = 0;
                end
            end else if (rx_valid && !parity_err) begin
                m_data = rx_data;
                m_hold = 1;
                if (!m_wait) m_tries = 0;
                m_wait = 0;
            end else begin
                m_fail = (rx_valid && !(m_wait && m_preq)) ||
                         (m_wait && !rx_valid && m_age >= TO - 1);
                m_age = m_age + 1;
                if (m_fail) begin
                    if (m_tries < MAXR) begin
                        m_tries++;
                        m_req  = 1;
                        m_wait = 1;
                        m_age  = 0;
                    end else begin
                        m_fault = 1;
                        m_wait  = 0;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("model valid", 32'(valid), 32'(m_hold));
        chk("model error", 32'(error), 32'(m_fault));
        chk("model data_out", 32'(data_out), 32'(m_data));
        chk("model request_resend", 32'(request_resend), 32'(m_req));
        chk("model overrun", 32'(overrun), 32'(m_ovr));
        chk("model retry_cnt", 32'(retry_cnt), 32'(m_tries));
    end

    task automatic tick(input logic v, input logic [7:0] d, input logic p,
                        input logic a, input logic c);
        rx_valid = v; rx_data = d; parity_err = p; ack = a; err_clr = c;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 8'h00, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("reset valid", 32'(valid), 0);
        chk("reset retry_cnt", 32'(retry_cnt), 0);
        rst = 1'b0;

        // Good frame, ack held low three cycles then high.
        tick(1, 8'hA5, 0, 0, 0);
        chk("good valid", 32'(valid), 1);
        chk("good data", 32'(data_out), 32'h A5);
        idle(2);
        tick(0, 8'h00, 0, 1, 0);
        chk("ack drop valid", 32'(valid), 0);
        chk("ack keeps data", 32'(data_out), 32'hA5);

        // Bad frame, good frame 10 cycles later.
        tick(1, 8'hFF, 1, 0, 0);
        chk("bad req", 32'(request_resend), 1);
        chk("bad retry", 32'(retry_cnt), 1);
        idle(1);
        chk("req one cycle", 32'(request_resend), 0);
        idle(8);
        tick(1, 8'h3C, 0, 0, 0);
        chk("resent valid", 32'(valid), 1);
        chk("resent data", 32'(data_out), 32'h3C);
        tick(0, 8'h00, 0, 1, 0);
        chk("resent retry clr", 32'(retry_cnt), 0);

        // Three bad frames exhaust MAX_RETRY=2.
        tick(1, 8'h01, 1, 0, 0);
        chk("b1 req", 32'(request_resend), 1);
        tick(1, 8'h02, 1, 0, 0);
        chk("b-adjacent no req", 32'(request_resend), 0);
        tick(1, 8'h03, 1, 0, 0);
        chk("b2 req", 32'(request_resend), 1);
        chk("b2 retry", 32'(retry_cnt), 2);
        idle(1);
        tick(1, 8'h04, 1, 0, 0);
        chk("b3 error", 32'(error), 1);
        chk("b3 no req", 32'(request_resend), 0);
        tick(1, 8'h77, 0, 0, 0);
        chk("error ignores rx", 32'(valid), 0);
        tick(0, 8'h00, 0, 0, 1);
        chk("clr error", 32'(error), 0);
        chk("clr retry", 32'(retry_cnt), 0);

        // Timeout: second request exactly TO cycles after the first.
        tick(1, 8'h00, 1, 0, 0);
        chk("to first req", 32'(request_resend), 1);
        idle(TO - 1);
        chk("to no early req", 32'(request_resend), 0);
        idle(1);
        chk("to second req", 32'(request_resend), 1);
        chk("to retry", 32'(retry_cnt), 2);
        idle(TO - 1);
        tick(1, 8'h5E, 0, 0, 0);
        chk("frame beats timeout", 32'(valid), 1);
        chk("no error on race", 32'(error), 0);
        chk("no req on race", 32'(request_resend), 0);
        tick(0, 8'h00, 0, 1, 0);

        // Overrun while holding 0x22.
        tick(1, 8'h22, 0, 0, 0);
        tick(1, 8'h11, 0, 0, 0);
        chk("overrun pulse", 32'(overrun), 1);
        chk("overrun data", 32'(data_out), 32'h22);
        tick(1, 8'h33, 0, 0, 0);
        chk("overrun not adjacent", 32'(overrun), 0);
        tick(0, 8'h00, 0, 1, 0);

        // Async reset mid-retry.
        tick(1, 8'h00, 1, 0, 0);
        idle(1);
        chk("pre-reset retry", 32'(retry_cnt), 1);
        #2 rst = 1'b1;
        #1;
        chk("async valid", 32'(valid), 0);
        chk("async retry", 32'(retry_cnt), 0);
        chk("async data", 32'(data_out), 0);
        chk("async error", 32'(error), 0);
        chk("async req", 32'(request_resend), 0);
        @(negedge clk);
        rst = 1'b0;
        tick(1, 8'h5A, 0, 0, 0);
        chk("post-reset valid", 32'(valid), 1);
        chk("post-reset data", 32'(data_out), 32'h5A);
        tick(0, 8'h00, 0, 1, 0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_retrans_ctrl.md
UART_RETRANS_CTRL -- requirements
Module: uart_retrans_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning received frame data width in bits.
REQ-002 The block SHALL have parameter MAX_RETRY, default 2, meaning the number of resend requests allowed per frame before error (range 1..15).
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 64, meaning the cycles to wait for a resent frame before counting the attempt as failed (range 2..65535).
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 rx_valid  input  1  one-cycle strobe: a frame has been received.
REQ-007 rx_data  input  DATA_W  frame data, qualified by rx_valid.
REQ-008 parity_err  input  1  parity/framing error for the current frame, qualified by rx_valid.
REQ-009 ack  input  1  downstream accepts data_out; a transfer occurs when valid&ack.
REQ-010 err_clr  input  1  clears the ERROR state.
REQ-011 data_out  output  DATA_W  latched good frame.
REQ-012 valid  output  1  data_out holds an unconsumed good frame.
REQ-013 request_resend  output  1  one-cycle pulse asking the transmitter to resend.
REQ-014 error  output  1  retry budget exhausted; level output.
REQ-015 overrun  output  1  one-cycle pulse: rx_valid arrived while valid was high (frame dropped).
REQ-016 retry_cnt  output  4  resend requests issued for the current frame.

Function
REQ-017 The FSM SHALL have states IDLE, WAIT_RESEND, RELEASE and ERROR; the reset state SHALL be IDLE.
REQ-018 IDLE: rx_valid & ~parity_err -> latch rx_data, go RELEASE, retry_cnt=0; rx_valid & parity_err -> request resend (REQ-021).
REQ-019 WAIT_RESEND: timer counts from 0; rx_valid & ~parity_err -> latch, RELEASE; rx_valid & parity_err, or timer reaching TIMEOUT_CYC-1 without rx_valid -> failed attempt (REQ-021).
REQ-020 If rx_valid arrives in the same cycle that the timer expires, the frame SHALL take precedence and the timeout SHALL be ignored.
REQ-021 On a failed attempt with retry_cnt<MAX_RETRY, the block SHALL pulse request_resend in the next cycle, increment retry_cnt, clear the timer and enter WAIT_RESEND; with retry_cnt==MAX_RETRY it SHALL enter ERROR with no pulse.
REQ-022 RELEASE: valid=1 and data_out is stable; on valid&ack, go IDLE in the next cycle, with valid low and retry_cnt=0.
REQ-023 rx_valid received in RELEASE SHALL be dropped with an overrun pulse on the next cycle; data_out SHALL NOT change.
REQ-024 ERROR: error=1 and rx_valid is ignored; err_clr -> IDLE with retry_cnt=0; error SHALL drop on the cycle the state leaves ERROR.
REQ-025 Latency: valid SHALL rise on the cycle after a good rx_valid, and request_resend SHALL assert on the cycle after the failing event.
REQ-026 request_resend and overrun SHALL never be high for two consecutive cycles.
REQ-027 The timer SHALL be TIMEOUT_CYC-wide-safe ($clog2), saturating, and SHALL be active only in WAIT_RESEND.

Reset
REQ-028 Reset assertion SHALL immediately force state=IDLE, valid=0, request_resend=0, error=0, overrun=0, retry_cnt=0, timer=0, data_out=0, including when asserted mid-retry or in RELEASE.
REQ-029 The first rx_valid sampled after reset deassertion SHALL be processed normally.

Structure
REQ-030 Package uart_retrans_pkg SHALL hold the state encoding constants and the default parameter values.
REQ-031 The timeout counter SHALL be a sub-module uart_retrans_timer (inputs clear and enable, output expired) instantiated once.

Verification
REQ-032 rx_valid, data=0xA5, parity_err=0, ack held low for 3 cycles then high -> valid rises 1 cycle later, data_out=0xA5, valid drops after the ack cycle.
REQ-033 Bad frame, then good frame 0x3C 10 cycles later -> one request_resend pulse, retry_cnt=1, then valid with data_out=0x3C and retry_cnt returns to 0.
REQ-034 MAX_RETRY=2 with three consecutive bad frames -> two request_resend pulses, then error=1; err_clr -> IDLE and error=0.
REQ-035 TIMEOUT_CYC=16 with no rx_valid after a resend -> second request_resend exactly 16 cycles after the first; a good rx_valid on cycle 15 -> RELEASE with no pulse.
REQ-036 rx_valid (0x11) while valid holds 0x22 -> overrun pulse, data_out stays 0x22.
REQ-037 Reset asserted in WAIT_RESEND with retry_cnt=1 -> all outputs 0 asynchronously; the next good frame is released normally.
